dac_stream_ctrl: RTL and testbench

- Digital front-end for one or more avsddac-style resistor-string DACs.
- Accepts a stream of {channel, code} samples over a valid/ready handshake and buffers them in a FIFO.
- Releases one sample per programmable sample-rate tick and holds a registered code per channel for the DAC's D inputs.
- Generalises the fixed 10-bit single DAC into parametrised code width, channel count and buffering, with underrun and bad-channel reporting.

---
 rtl/dac_stream_ctrl_pkg.sv | 19 +
 rtl/dac_stream_ctrl_if.sv | 13 +
 rtl/dac_sample_fifo.sv | 58 +++++
 rtl/dac_stream_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dac_stream_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_stream_ctrl_pkg.sv
// Shared types and constants for the DAC stream controller.
package dac_stream_pkg;

    localparam int unsigned CODE_W_DEF = 10;
    localparam int unsigned NUM_CH_DEF = 2;

    // Channel-index width; a single channel still needs one select bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CH_W_DEF = ch_width(NUM_CH_DEF);

    typedef struct packed {
        logic [CH_W_DEF-1:0]   ch;
        logic [CODE_W_DEF-1:0] code;
    } sample_t;

endpackage

// File: rtl/dac_stream_ctrl_if.sv
// Valid/ready sample stream carrying {channel, code}.
interface dac_stream_ctrl_if #(
    parameter int unsigned CH_W   = 1,
    parameter int unsigned CODE_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [CH_W-1:0]   in_ch;
    logic [CODE_W-1:0] in_code;

    modport master (output in_valid, output in_ch, output in_code, input in_ready);
    modport slave  (input in_valid, input in_ch, input in_code, output in_ready);
endinterface

// File: rtl/dac_sample_fifo.sv
// Single-clock sample FIFO; head entry is readable combinationally.
module dac_sample_fifo #(
    parameter int unsigned  W     = 8,
    parameter int unsigned  DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LVL_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata_c,
    output logic             full_c,
    output logic             empty_c,
    output logic [LVL_W-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok_c;
    logic          pop_ok_c;

    assign full_c    = (level == LVL_W'(DEPTH));
    assign empty_c   = (level == '0);
    assign push_ok_c = push && !full_c;
    assign pop_ok_c  = pop && !empty_c;
    assign rdata_c   = mem[rd_ptr];

    // Storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok_c, pop_ok_c})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_stream_ctrl.sv
// Buffered sample stream to per-channel DAC code registers, released on a divided tick.
// Optional DAC_SLEW_EN: codes slew toward per-channel targets by SLEW_STEP per tick.
module dac_stream_ctrl
    import dac_stream_pkg::*;
#(
    parameter int unsigned CODE_W     = CODE_W_DEF,
    parameter int unsigned NUM_CH     = NUM_CH_DEF,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned SLEW_STEP  = 16
) (
    input  logic                         CLK,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [DIV_W-1:0]             div,
    dac_stream_ctrl_if.slave             s,
    output logic [NUM_CH*CODE_W-1:0]     dac_code,
    output logic [NUM_CH-1:0]            dac_update,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         underrun,
    output logic                         bad_ch,
    input  logic                         status_clr
);

    localparam int unsigned CH_W  = ch_width(NUM_CH);
    localparam int unsigned ENT_W = CH_W + CODE_W;

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("NUM_CH must be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (SLEW_STEP < 1) begin : g_bad_step
        $error("SLEW_STEP must be >= 1");
    end

    logic [DIV_W-1:0]  count;
    logic              tick_c;
    logic              push_c;
    logic              pop_c;
    logic              wr_c;
    logic              full_c;
    logic              empty_c;
    logic              ch_ok_c;
    logic [ENT_W-1:0]  head_c;
    logic [CH_W-1:0]   head_ch_c;
    logic [CODE_W-1:0] head_code_c;

    logic [CODE_W-1:0] code_q [NUM_CH];
    logic [CODE_W-1:0] code_d [NUM_CH];
    logic [NUM_CH-1:0] upd_d;

    // Sample-rate divider; div is compared live so a new period applies at once.
    assign tick_c = enable && (count == div);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!enable || tick_c) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

    assign s.in_ready  = !full_c;
    assign push_c      = s.in_valid && !full_c;
    assign pop_c       = tick_c && !empty_c;
    assign head_ch_c   = head_c[ENT_W-1:CODE_W];
    assign head_code_c = head_c[CODE_W-1:0];
    assign ch_ok_c     = (32'(head_ch_c) < NUM_CH);
    assign wr_c        = pop_c && ch_ok_c;

    dac_sample_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (reset_n),
        .push    (push_c),
        .pop     (pop_c),
        .wdata   ({s.in_ch, s.in_code}),
        .rdata_c (head_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .level   (fifo_level)
    );

`ifdef DAC_SLEW_EN
    logic [CODE_W-1:0] tgt_q [NUM_CH];
    logic [CODE_W-1:0] tgt_d [NUM_CH];

    // Each channel steps toward its (possibly just-written) target on every tick.
    always_comb begin
        logic [CODE_W-1:0] diff;
        diff  = '0;
        upd_d = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            tgt_d[i]  = tgt_q[i];
            code_d[i] = code_q[i];
            if (wr_c && head_ch_c == CH_W'(i)) begin
                tgt_d[i] = head_code_c;
            end
            if (tick_c && code_q[i] != tgt_d[i]) begin
                upd_d[i] = 1'b1;
                if (tgt_d[i] > code_q[i]) begin
                    diff      = tgt_d[i] - code_q[i];
                    code_d[i] = (32'(diff) > SLEW_STEP) ? code_q[i] + CODE_W'(SLEW_STEP) : tgt_d[i];
                end else begin
                    diff      = code_q[i] - tgt_d[i];
                    code_d[i] = (32'(diff) > SLEW_STEP) ? code_q[i] - CODE_W'(SLEW_STEP) : tgt_d[i];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                tgt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                tgt_q[i] <= tgt_d[i];
            end
        end
    end
`else
    // A valid pop overwrites the channel code directly, even with an equal value.
    always_comb begin
        upd_d = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            code_d[i] = code_q[i];
            if (wr_c && head_ch_c == CH_W'(i)) begin
                code_d[i] = head_code_c;
                upd_d[i]  = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                code_q[i] <= '0;
            end
            dac_update <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                code_q[i] <= code_d[i];
            end
            dac_update <= upd_d;
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_pack
        assign dac_code[g*CODE_W +: CODE_W] = code_q[g];
    end

    // Sticky status; a set event in the same cycle as a clear wins.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            underrun <= 1'b0;
            bad_ch   <= 1'b0;
        end else begin
            if (tick_c && empty_c) begin
                underrun <= 1'b1;
            end else if (status_clr) begin
                underrun <= 1'b0;
            end
            if (pop_c && !ch_ok_c) begin
                bad_ch <= 1'b1;
            end else if (status_clr) begin
                bad_ch <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_stream_ctrl.sv
// Randomised bench for dac_stream_ctrl against a queue-based reference model.
module tb_dac_stream_ctrl;
    import dac_stream_pkg::*;

    localparam int unsigned CODE_W     = 10;
    localparam int unsigned NUM_CH     = 3;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned DIV_W      = 16;
    localparam int unsigned SLEW_STEP  = 16;
    localparam int unsigned CH_W       = ch_width(NUM_CH);
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic                     CLK;
    logic                     reset_n;
    logic                     enable;
    logic [DIV_W-1:0]         div;
    logic                     status_clr;
    logic [NUM_CH*CODE_W-1:0] dac_code;
    logic [NUM_CH-1:0]        dac_update;
    logic [LVL_W-1:0]         fifo_level;
    logic                     underrun;
    logic                     bad_ch;

    dac_stream_ctrl_if #(.CH_W(CH_W), .CODE_W(CODE_W)) sif ();

    dac_stream_ctrl #(
        .CODE_W     (CODE_W),
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W),
        .SLEW_STEP  (SLEW_STEP)
    ) dut (
        .CLK        (CLK),
        .reset_n    (reset_n),
        .enable     (enable),
        .div        (div),
        .s          (sif),
        .dac_code   (dac_code),
        .dac_update (dac_update),
        .fifo_level (fifo_level),
        .underrun   (underrun),
        .bad_ch     (bad_ch),
        .status_clr (status_clr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_chk;
    int n_pass;

    // Reference model state
    int q_ch[$];
    int q_code[$];
    int m_cnt;
    int m_code[NUM_CH];
    int m_tgt[NUM_CH];
    int m_upd[NUM_CH];
    bit m_und;
    bit m_bad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q_ch.delete();
        q_code.delete();
        m_cnt = 0;
        m_und = 1'b0;
        m_bad = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            m_code[i] = 0;
            m_tgt[i]  = 0;
            m_upd[i]  = 0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit tick;
        bit push;
        bit pop;
        bit was_empty;
        int hch;
        int hcode;
        hch       = 0;
        hcode     = 0;
        tick      = enable && (m_cnt == int'(div));
        was_empty = (q_ch.size() == 0);
        push      = sif.in_valid && (q_ch.size() < int'(FIFO_DEPTH));
        pop       = tick && !was_empty;
        for (int i = 0; i < int'(NUM_CH); i++) m_upd[i] = 0;
        if (pop) begin
            hch   = q_ch.pop_front();
            hcode = q_code.pop_front();
        end
        if (pop && hch < int'(NUM_CH)) begin
`ifdef DAC_SLEW_EN
            m_tgt[hch] = hcode;
`else
            m_code[hch] = hcode;
            m_upd[hch]  = 1;
`endif
        end
`ifdef DAC_SLEW_EN
        if (tick) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                int d;
                d = m_tgt[i] - m_code[i];
                if (d != 0) begin
                    if (d > int'(SLEW_STEP)) m_code[i] += int'(SLEW_STEP);
                    else if (d < -int'(SLEW_STEP)) m_code[i] -= int'(SLEW_STEP);
                    else m_code[i] = m_tgt[i];
                    m_upd[i] = 1;
                end
            end
        end
`endif
        if (tick && was_empty) m_und = 1'b1;
        else if (status_clr) m_und = 1'b0;
        if (pop && hch >= int'(NUM_CH)) m_bad = 1'b1;
        else if (status_clr) m_bad = 1'b0;
        if (push) begin
            q_ch.push_back(int'(sif.in_ch));
            q_code.push_back(int'(sif.in_code));
        end
        if (!enable || tick) m_cnt = 0;
        else m_cnt = (m_cnt + 1) % 65536;
    endtask

    task automatic check_outputs();
        logic [NUM_CH*CODE_W-1:0] ec;
        logic [NUM_CH-1:0]        eu;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            ec[i*CODE_W +: CODE_W] = CODE_W'(m_code[i]);
            eu[i]                  = (m_upd[i] != 0);
        end
        chk("fifo_level", 64'(fifo_level), 64'(q_ch.size()));
        chk("dac_code", 64'(dac_code), 64'(ec));
        chk("dac_update", 64'(dac_update), 64'(eu));
        chk("underrun", 64'(underrun), 64'(m_und));
        chk("bad_ch", 64'(bad_ch), 64'(m_bad));
    endtask

    task automatic cycle();
        chk("in_ready", 64'(sif.in_ready), 64'(q_ch.size() < int'(FIFO_DEPTH)));
        model_step();
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge CLK);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic push_one(input int ch, input int code);
        sif.in_valid = 1'b1;
        sif.in_ch    = CH_W'(ch);
        sif.in_code  = CODE_W'(code);
        cycle();
        sif.in_valid = 1'b0;
    endtask

    initial begin
        n_chk        = 0;
        n_pass       = 0;
        reset_n      = 1'b0;
        enable       = 1'b0;
        div          = '0;
        status_clr   = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_ch    = '0;
        sif.in_code  = '0;
        model_reset();
        #2;
        do_reset();

        // Two samples at div=3: first tick in cycle 3, codes visible one cycle later
        enable = 1'b1;
        div    = DIV_W'(3);
        push_one(0, 512);
        push_one(1, 1023);
        for (int k = 0; k < 8; k++) cycle();
`ifndef DAC_SLEW_EN
        chk("ch0_512", 64'(dac_code[CODE_W-1:0]), 64'd512);
        chk("ch1_1023", 64'(dac_code[2*CODE_W-1:CODE_W]), 64'd1023);
`endif

        // Fill with ticks disabled; ninth sample refused
        enable = 1'b0;
        for (int k = 0; k < 9; k++) push_one(int'($urandom_range(0, 2)), int'($urandom_range(0, 1023)));
        chk("full_ready", 64'(sif.in_ready), 64'd0);
        chk("full_level", 64'(fifo_level), 64'(FIFO_DEPTH));
        enable = 1'b1;
        div    = '0;
        for (int k = 0; k < 9; k++) cycle();

        // Empty ticks, then clear colliding with an underrun tick
        div = DIV_W'(1);
        for (int k = 0; k < 5; k++) cycle();
        for (int k = 0; k < 4 && m_cnt != int'(div); k++) cycle();
        status_clr = 1'b1;
        cycle();
        status_clr = 1'b0;
        chk("clr_vs_set", 64'(underrun), 64'd1);
        status_clr = 1'b1;
        cycle();
        status_clr = 1'b0;

        // Out-of-range channel
        push_one(3, 100);
        for (int k = 0; k < 4; k++) cycle();
        chk("bad_ch_set", 64'(bad_ch), 64'd1);

        // Reset with samples queued
        enable = 1'b0;
        for (int k = 0; k < 5; k++) push_one(int'($urandom_range(0, 2)), int'($urandom_range(0, 1023)));
        do_reset();
        chk("rst_level", 64'(fifo_level), 64'd0);
        enable = 1'b1;
        div    = DIV_W'(2);
        for (int k = 0; k < 4; k++) cycle();

        // Random traffic
        for (int k = 0; k < 2000; k++) begin
            sif.in_valid = 1'($urandom_range(0, 1));
            sif.in_ch    = CH_W'($urandom_range(0, 3));
            sif.in_code  = CODE_W'($urandom_range(0, 1023));
            status_clr   = ($urandom_range(0, 15) == 0);
            enable       = ($urandom_range(0, 9) != 0);
            if (m_cnt == 0 && $urandom_range(0, 7) == 0) div = DIV_W'($urandom_range(0, 4));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
